// File: rtl/ped_button_conditioner_if.sv
// ----------------------------------------------------------------------------
// ped_button_conditioner_if
// Bundles the pedestrian push-button conditioner's data signals.
//   button_raw  : raw push-button level, asynchronous to clk, may bounce
//   served      : one-cycle pulse from the light controller (phase granted)
//   ped_request : registered request level to the light controller
//   cooldown    : registered, high while request latching is suppressed
//   press_count : registered count of debounced presses, saturating at 255
// Modports:
//   master : the light controller / environment side (drives button, served)
//   slave  : the conditioner itself
// ----------------------------------------------------------------------------
interface ped_button_conditioner_if;
    logic       button_raw;
    logic       served;
    logic       ped_request;
    logic       cooldown;
    logic [7:0] press_count;

    modport master (
        output button_raw,
        output served,
        input  ped_request,
        input  cooldown,
        input  press_count
    );

    modport slave (
        input  button_raw,
        input  served,
        output ped_request,
        output cooldown,
        output press_count
    );
endinterface

// File: rtl/ped_button_conditioner.sv
// ----------------------------------------------------------------------------
// ped_button_conditioner
// Synchronizes and debounces a pedestrian push-button, latches one pending
// request towards the light controller, and suppresses new requests for a
// fixed cooldown period after each served request.
// Ports:
//   clk     : system clock, all state updates on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ped_button_conditioner_if.slave (button_raw, served in;
//             ped_request, cooldown, press_count out, all registered)
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized samples to change level (1..15)
//   COOLDOWN_CYCLES : cycles of request suppression after service (1..255)
// ----------------------------------------------------------------------------
module ped_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ped_button_conditioner_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_CYCLES - 1);

    logic       sync1_q;
    logic       btn_sync_q;
    logic       deb_q;
    logic       deb_d;
    logic [3:0] dcnt_q;
    logic [3:0] dcnt_d;
    logic       press_s;

    state_t     state_q;
    logic [7:0] ctimer_q;
    logic       ped_request_q;
    logic       cooldown_q;
    logic [7:0] press_count_q;

    // Debounce next-state: count consecutive disagreeing samples, flip on the last one.
    always_comb begin
        deb_d   = deb_q;
        dcnt_d  = 4'd0;
        press_s = 1'b0;
        if (btn_sync_q != deb_q) begin
            if (dcnt_q == DEB_LAST) begin
                deb_d   = btn_sync_q;
                dcnt_d  = 4'd0;
                // Only the rising debounced edge is a press; releases are silent.
                press_s = btn_sync_q;
            end else begin
                dcnt_d  = dcnt_q + 4'd1;
            end
        end else begin
            dcnt_d = 4'd0;
        end
    end

    // Two-flop synchronizer plus debounced level and its counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            btn_sync_q <= 1'b0;
            deb_q      <= 1'b0;
            dcnt_q     <= 4'd0;
        end else begin
            sync1_q    <= bus.button_raw;
            btn_sync_q <= sync1_q;
            deb_q      <= deb_d;
            dcnt_q     <= dcnt_d;
        end
    end

    // Request FSM with registered outputs and saturating press counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ctimer_q      <= 8'd0;
            ped_request_q <= 1'b0;
            cooldown_q    <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            if (press_s && (press_count_q != 8'd255)) begin
                press_count_q <= press_count_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (press_s) begin
                        state_q       <= ST_ARMED;
                        ped_request_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // Presses while armed merge into the pending request;
                    // served takes priority over a coincident press.
                    if (bus.served) begin
                        state_q       <= ST_COOLDOWN;
                        ped_request_q <= 1'b0;
                        cooldown_q    <= 1'b1;
                        ctimer_q      <= 8'd0;
                    end
                end
                ST_COOLDOWN: begin
                    // Presses here (including the expiry edge) are never latched.
                    if (ctimer_q == COOL_LAST) begin
                        state_q    <= ST_IDLE;
                        cooldown_q <= 1'b0;
                        ctimer_q   <= 8'd0;
                    end else begin
                        ctimer_q   <= ctimer_q + 8'd1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    ped_request_q <= 1'b0;
                    cooldown_q    <= 1'b0;
                    ctimer_q      <= 8'd0;
                end
            endcase
        end
    end

    assign bus.ped_request = ped_request_q;
    assign bus.cooldown    = cooldown_q;
    assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_ped_button_conditioner
// Directed bench for ped_button_conditioner with default parameters
// (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8). A vector table drives one long
// press/serve/release scenario; hand-written sequences cover bounce
// rejection, presses inside and at the end of cooldown, served coinciding
// with a press, saturation and asynchronous reset.
// Edge numbering: edge 1 is the first rising edge after reset_n is released.
// ----------------------------------------------------------------------------
module tb_ped_button_conditioner;

    logic clk;
    logic reset_n;

    ped_button_conditioner_if bus ();

    ped_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .COOLDOWN_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic       srv;
        int         reps;
        logic       req;
        logic       cool;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic b, input logic s, input int r,
                       input logic q, input logic c, input logic [7:0] n);
        vec_t v;
        v.btn = b; v.srv = s; v.reps = r; v.req = q; v.cool = c; v.cnt = n;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic q, input logic c,
                       input logic [7:0] n);
        n_tests++;
        if (bus.ped_request !== q || bus.cooldown !== c || bus.press_count !== n) begin
            n_fail++;
            $display("FAIL %s: got req=%b cool=%b cnt=%0d, expected req=%b cool=%b cnt=%0d",
                     name, bus.ped_request, bus.cooldown, bus.press_count, q, c, n);
        end
    endtask

    // Apply inputs for one edge, then sample 1 time unit after that edge.
    task automatic step(input logic b, input logic s);
        bus.button_raw = b;
        bus.served     = s;
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check the cleared outputs, release at a falling edge.
    task automatic do_reset(input logic b);
        bus.button_raw = b;
        bus.served     = 1'b0;
        reset_n        = 1'b0;
        #2;
        chk("reset_state", 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Press (armed at edge 6), release edges 7..10 (deb falls at 12),
    // press again from edge 11 (deb rises at 16). Optional served pulse.
    task automatic prefix(input int srv_edge);
        for (int k = 1; k <= 15; k++) begin
            step(!(k >= 7 && k <= 10), k == srv_edge);
            if (k == 6) chk("prefix_arm", 1'b1, 1'b0, 8'd1);
            if (k == srv_edge) chk("prefix_served", 1'b0, 1'b1, 8'd1);
        end
    endtask

    initial begin
        logic [7:0] exp_cnt;
        reset_n        = 1'b0;
        bus.button_raw = 1'b0;
        bus.served     = 1'b0;

        // ---------------- table-driven main scenario ----------------
        add(1'b1, 1'b0, 5, 1'b0, 1'b0, 8'd0);  // edges 1-5: still debouncing
        add(1'b1, 1'b0, 3, 1'b1, 1'b0, 8'd1);  // edge 6: press, armed
        add(1'b1, 1'b1, 1, 1'b0, 1'b1, 8'd1);  // edge 9: served
        add(1'b1, 1'b0, 7, 1'b0, 1'b1, 8'd1);  // edges 10-16: cooldown
        add(1'b1, 1'b0, 1, 1'b0, 1'b0, 8'd1);  // edge 17: back to idle
        add(1'b0, 1'b0, 6, 1'b0, 1'b0, 8'd1);  // edges 18-23: release, no event
        add(1'b0, 1'b1, 1, 1'b0, 1'b0, 8'd1);  // edge 24: served in idle ignored
        add(1'b1, 1'b0, 5, 1'b0, 1'b0, 8'd1);  // edges 25-29
        add(1'b1, 1'b0, 1, 1'b1, 1'b0, 8'd2);  // edge 30: second press
        add(1'b0, 1'b0, 6, 1'b1, 1'b0, 8'd2);  // edges 31-36: release while armed
        add(1'b1, 1'b0, 5, 1'b1, 1'b0, 8'd2);  // edges 37-41
        add(1'b1, 1'b0, 1, 1'b1, 1'b0, 8'd3);  // edge 42: merged press
        add(1'b1, 1'b1, 1, 1'b0, 1'b1, 8'd3);  // edge 43: served
        add(1'b1, 1'b0, 7, 1'b0, 1'b1, 8'd3);  // edges 44-50
        add(1'b1, 1'b0, 1, 1'b0, 1'b0, 8'd3);  // edge 51

        do_reset(1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].btn, tbl[i].srv);
                chk($sformatf("tbl[%0d].%0d", i, r), tbl[i].req, tbl[i].cool, tbl[i].cnt);
            end
        end

        // ---------------- bounce rejection ----------------
        do_reset(1'b0);
        for (int k = 0; k < 20; k++) begin
            step(k[0] == 1'b0, 1'b0);
            chk("bounce", 1'b0, 1'b0, 8'd0);
        end

        // ---------------- press completing inside cooldown ----------------
        do_reset(1'b1);
        prefix(12);                                   // served at edge 12
        step(1'b1, 1'b0); chk("cd_press_e16", 1'b0, 1'b1, 8'd2);
        for (int k = 17; k <= 19; k++) step(1'b1, 1'b0);
        chk("cd_still_e19", 1'b0, 1'b1, 8'd2);
        step(1'b1, 1'b0); chk("cd_end_e20", 1'b0, 1'b0, 8'd2);
        for (int k = 21; k <= 23; k++) begin
            step(1'b1, 1'b0);
            chk("cd_not_latched", 1'b0, 1'b0, 8'd2);
        end

        // ---------------- served and press on the same edge ----------------
        do_reset(1'b1);
        prefix(0);
        step(1'b1, 1'b1); chk("srv_press_e16", 1'b0, 1'b1, 8'd2);
        for (int k = 17; k <= 19; k++) step(1'b1, 1'b0);
        chk("srv_press_cd", 1'b0, 1'b1, 8'd2);
        // reset in the middle of cooldown
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_cd", 1'b0, 1'b0, 8'd0);
        bus.button_raw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            chk("after_rst_cd", 1'b0, 1'b0, 8'd0);
        end

        // ---------------- merge while armed, press on cooldown expiry ----------
        do_reset(1'b1);
        prefix(0);
        step(1'b1, 1'b0); chk("merge_e16", 1'b1, 1'b0, 8'd2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1); chk("served_e19", 1'b0, 1'b1, 8'd2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 22; k <= 26; k++) step(1'b1, 1'b0);
        chk("cd_e26", 1'b0, 1'b1, 8'd2);
        step(1'b1, 1'b0); chk("expiry_press_e27", 1'b0, 1'b0, 8'd3);
        step(1'b1, 1'b0); chk("expiry_after1", 1'b0, 1'b0, 8'd3);
        step(1'b1, 1'b0); chk("expiry_after2", 1'b0, 1'b0, 8'd3);

        // ---------------- saturation over 300 presses ----------------
        do_reset(1'b0);
        exp_cnt = 8'd0;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
            if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("sat_press_%0d", i), 1'b1, 1'b0, exp_cnt);
            step(1'b0, 1'b1);
            for (int k = 0; k < 11; k++) step(1'b0, 1'b0);
        end
        chk("sat_idle", 1'b0, 1'b0, 8'd255);

        // ---------------- async reset mid-ARMED, button held through ----------
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
        chk("sat_armed", 1'b1, 1'b0, 8'd255);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_armed", 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0);
            chk("held_after_rst", 1'b0, 1'b0, 8'd0);
        end
        step(1'b1, 1'b0); chk("held_press_e6", 1'b1, 1'b0, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
